uop_buffer_responder: RTL

// - Responder side of the uop read interface driven by the address-offset generator: owns the uop SRAM and answers uop_read_req/uop_read_addr with uop_read_data.
// - Also owns the load path that fills the SRAM from an upstream valid/ready stream before an instruction runs.
// - Sits between instruction fetch (writer) and the address generator (reader).

---
 rtl/uop_buffer_responder_pkg.sv | 31 +++
 rtl/uop_sram.sv | 95 +++++++++
 rtl/uop_buffer_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uop_buffer_responder_pkg.sv
// ---------------------------------------------------------------------------
// uop_buffer_responder_pkg
//
// Purpose:
//   Shared types and default sizing for the uop buffer responder slice.
//   Holds the load FSM state encoding and the default geometry of the uop
//   SRAM so that the top, the storage sub-module and any bench agree on it.
//
// Contents:
//   load_state_t          IDLE / LOAD / DONE states of the load sequencer
//   UOP_DATA_WIDTH_DFLT   default uop word width
//   UOP_ADDR_W_DFLT       default requester read address width
//   UOP_DEPTH_DFLT        default number of uop entries (power of two)
//   LOAD_CNT_W_DFLT       default width of load_num and the load counter
//   UOP_IDX_W             index width of the default-depth SRAM
// ---------------------------------------------------------------------------
package uop_buffer_responder_pkg;

   localparam int UOP_DATA_WIDTH_DFLT = 8;
   localparam int UOP_ADDR_W_DFLT     = 48;
   localparam int UOP_DEPTH_DFLT      = 1024;
   localparam int LOAD_CNT_W_DFLT     = 16;
   localparam int UOP_IDX_W           = $clog2(UOP_DEPTH_DFLT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } load_state_t;

endpackage

// File: rtl/uop_sram.sv
// ---------------------------------------------------------------------------
// uop_sram
//
// Purpose:
//   Storage array for the uop buffer with a registered read port. The read
//   data register is the only state that is reset; array contents survive
//   reset on purpose so that a partial load is still readable afterwards.
//
// Configuration macro:
//   UOP_RD_BYPASS_EN  defined   -> 1R1W array, a read and a write may share a
//                                  cycle; a read of the entry being written
//                                  returns the incoming write data.
//                     undefined -> 1RW array, one shared address; the caller
//                                  guarantees read and write never collide.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset (read data register only)
//   i_rdEn    in   read enable, data appears on o_rdData after the edge
//   i_rdIdx   in   read index
//   i_wrEn    in   write enable
//   i_wrIdx   in   write index
//   i_wrData  in   write data
//   o_rdData  out  registered read data, holds when no read is issued
// ---------------------------------------------------------------------------
module uop_sram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_rdEn,
   input  logic [IDX_W-1:0]  i_rdIdx,
   input  logic              i_wrEn,
   input  logic [IDX_W-1:0]  i_wrIdx,
   input  logic [DATA_W-1:0] i_wrData,
   output logic [DATA_W-1:0] o_rdData
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdData;

   assign o_rdData = r_rdData;

`ifdef UOP_RD_BYPASS_EN

   // Independent write port of the 1R1W array.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrIdx] <= i_wrData;
      end
   end

   // Independent read port. When the read hits the entry written in the same
   // cycle the array still holds the old word, so the new word is forwarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         if (i_wrEn && (i_wrIdx == i_rdIdx)) begin
            r_rdData <= i_wrData;
         end else begin
            r_rdData <= r_mem[i_rdIdx];
         end
      end
   end

`else

   logic [IDX_W-1:0] w_addr;

   // Single shared address: a write claims the port, otherwise the read does.
   assign w_addr = i_wrEn ? i_wrIdx : i_rdIdx;

   // Write side of the single port.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[w_addr] <= i_wrData;
      end
   end

   // Read side of the single port; a read can only use the port when no
   // write owns it this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdData <= '0;
      end else if (i_rdEn && !i_wrEn) begin
         r_rdData <= r_mem[w_addr];
      end
   end

`endif

endmodule

// File: rtl/uop_buffer_responder.sv
// ---------------------------------------------------------------------------
// uop_buffer_responder
//
// Purpose:
//   Responder side of the uop read interface used by the address-offset
//   generator. Owns the uop SRAM, answers one read per cycle with a fixed
//   one-cycle latency, and fills the SRAM from an upstream valid/ready stream
//   under control of a small IDLE/LOAD/DONE sequencer.
//
// Configuration macro:
//   UOP_RD_BYPASS_EN  defined   -> loads ignore read requests (1R1W array,
//                                  same-cycle read of the written entry sees
//                                  the new data)
//                     undefined -> reads have priority over load writes on a
//                                  single-port array (default build)
//
// Ports:
//   clk             in   clock
//   reset           in   synchronous active-high reset
//   uop_read_req    in   read request, one per cycle, never stalled
//   uop_read_addr   in   read address (full width checked against depth)
//   uop_read_data   out  read data, one cycle after the request
//   uop_read_valid  out  high the cycle after a request
//   uop_read_oob    out  sticky out-of-range read flag
//   load_start      in   one-cycle pulse starting a load (ignored unless IDLE)
//   load_base       in   first entry written by the load
//   load_num        in   number of words to write
//   wr_data         in   load stream data
//   wr_valid        in   load stream valid
//   wr_ready        out  load stream ready
//   load_busy       out  high while in LOAD
//   load_done       out  one-cycle pulse when a load completes
// ---------------------------------------------------------------------------
module uop_buffer_responder
   import uop_buffer_responder_pkg::*;
#(
   parameter int UOP_DATA_WIDTH       = UOP_DATA_WIDTH_DFLT,
   parameter int UOP_MEM_ADDR_WIDTH_W = UOP_ADDR_W_DFLT,
   parameter int UOP_DEPTH            = UOP_DEPTH_DFLT,
   parameter int LOAD_CNT_W           = LOAD_CNT_W_DFLT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            uop_read_req,
   input  logic [UOP_MEM_ADDR_WIDTH_W-1:0] uop_read_addr,
   output logic [UOP_DATA_WIDTH-1:0]       uop_read_data,
   output logic                            uop_read_valid,
   output logic                            uop_read_oob,
   input  logic                            load_start,
   input  logic [$clog2(UOP_DEPTH)-1:0]    load_base,
   input  logic [LOAD_CNT_W-1:0]           load_num,
   input  logic [UOP_DATA_WIDTH-1:0]       wr_data,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   output logic                            load_busy,
   output logic                            load_done
);

   localparam int IDX_W = $clog2(UOP_DEPTH);
   localparam logic [UOP_MEM_ADDR_WIDTH_W-1:0] DEPTH_LIMIT =
      UOP_MEM_ADDR_WIDTH_W'(UOP_DEPTH);

   load_state_t               r_state;
   logic [IDX_W-1:0]          r_loadBase;
   logic [LOAD_CNT_W-1:0]     r_loadNum;
   logic [LOAD_CNT_W-1:0]     r_loadCnt;
   logic                      r_loadBusy;
   logic                      r_loadDone;
   logic                      r_readValid;
   logic                      r_readZeroSel;
   logic                      r_readOob;

   logic                      w_rdInRange;
   logic                      w_rdEn;
   logic [IDX_W-1:0]          w_rdIdx;
   logic                      w_loadRemaining;
   logic                      w_loadAccept;
   logic                      w_wrReady;
   logic                      w_wrFire;
   logic [IDX_W-1:0]          w_wrIdx;
   logic [LOAD_CNT_W-1:0]     w_cntNext;
   logic [UOP_DATA_WIDTH-1:0] w_sramRdData;

   // The whole address is compared, so high garbage bits can never alias
   // onto a valid entry.
   assign w_rdInRange = (uop_read_addr < DEPTH_LIMIT);
   assign w_rdEn      = uop_read_req && w_rdInRange;
   assign w_rdIdx     = uop_read_addr[IDX_W-1:0];

   // A zero-length load must not advertise ready, otherwise a beat could be
   // handshaken and silently discarded on the way to DONE.
   assign w_loadRemaining = (r_loadCnt != r_loadNum);
   assign w_loadAccept    = (r_state == IDLE) && load_start;

`ifdef UOP_RD_BYPASS_EN
   assign w_wrReady = (r_state == LOAD) && w_loadRemaining;
`else
   assign w_wrReady = (r_state == LOAD) && w_loadRemaining && !uop_read_req;
`endif

   assign w_wrFire  = w_wrReady && wr_valid;
   assign w_cntNext = r_loadCnt + LOAD_CNT_W'(1);

   // Base plus count wraps naturally by truncation to the index width.
   assign w_wrIdx = r_loadBase + IDX_W'(r_loadCnt);

   assign wr_ready       = w_wrReady;
   assign load_busy      = r_loadBusy;
   assign load_done      = r_loadDone;
   assign uop_read_valid = r_readValid;
   assign uop_read_oob   = r_readOob;
   assign uop_read_data  = r_readZeroSel ? '0 : w_sramRdData;

   uop_sram #(
      .DATA_W (UOP_DATA_WIDTH),
      .DEPTH  (UOP_DEPTH),
      .IDX_W  (IDX_W)
   ) u_sram (
      .clk      (clk),
      .reset    (reset),
      .i_rdEn   (w_rdEn),
      .i_rdIdx  (w_rdIdx),
      .i_wrEn   (w_wrFire),
      .i_wrIdx  (w_wrIdx),
      .i_wrData (wr_data),
      .o_rdData (w_sramRdData)
   );

   // Load sequencer. Base and length are captured when the load is accepted
   // so upstream may change them freely afterwards. The counter advances only
   // on an accepted beat; the final beat moves straight to DONE, where the
   // registered done pulse is high for exactly one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_loadBase <= '0;
         r_loadNum  <= '0;
         r_loadCnt  <= '0;
         r_loadBusy <= 1'b0;
         r_loadDone <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_loadDone <= 1'b0;
               if (load_start) begin
                  r_loadBase <= load_base;
                  r_loadNum  <= load_num;
                  r_loadCnt  <= '0;
                  r_loadBusy <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               if (!w_loadRemaining) begin
                  r_loadBusy <= 1'b0;
                  r_loadDone <= 1'b1;
                  r_state    <= DONE;
               end else if (w_wrFire) begin
                  r_loadCnt <= w_cntNext;
                  if (w_cntNext == r_loadNum) begin
                     r_loadBusy <= 1'b0;
                     r_loadDone <= 1'b1;
                     r_state    <= DONE;
                  end
               end
            end
            DONE: begin
               r_loadDone <= 1'b0;
               r_state    <= IDLE;
            end
            default: begin
               r_loadBusy <= 1'b0;
               r_loadDone <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   // Read response tracking. Valid simply follows the request by one cycle.
   // The zero-select remembers whether the last request was out of range so
   // the returned word is forced to zero and keeps holding while idle. The
   // sticky flag is cleared by an accepted load; a new out-of-range read in
   // that same cycle wins because it is the more recent event.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_readValid   <= 1'b0;
         r_readZeroSel <= 1'b0;
         r_readOob     <= 1'b0;
      end else begin
         r_readValid <= uop_read_req;
         if (uop_read_req) begin
            r_readZeroSel <= !w_rdInRange;
         end
         if (uop_read_req && !w_rdInRange) begin
            r_readOob <= 1'b1;
         end else if (w_loadAccept) begin
            r_readOob <= 1'b0;
         end
      end
   end

endmodule
